tx_ack_scheduler: RTL and testbench
===================================

# tx_ack_scheduler

Round-robin scheduler that shares a single transmitter between `NUM_REQ` requesters and sequences each transfer. Per transfer: issue a one-cycle `tx_pulse`, then count acknowledge beats on `rx_ack` starting the next cycle. Gaps between beats are allowed; the beats need not be consecutive. The transfer completes after exactly `ACK_COUNT` beats, or fails on timeout. The block sits between the requester agents and the transmitter/receiver pair and produces the protocol `transmit |-> ##1 rx[=ACK_COUNT]` by construction.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ACK_COUNT`, default 2: acknowledge beats required per transfer; must be ≥1.
- `TIMEOUT`, default 16: maximum number of WAIT cycles; must be ≥ `ACK_COUNT`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `NUM_REQ`: level request per requester; sampled only in IDLE.
- `grant`, out, `NUM_REQ`: one-hot owner; held from TX through DONE.
- `tx_pulse`, out, 1: one-cycle transmit strobe to the transmitter.
- `rx_ack`, in, 1: acknowledge beat from the receiver; one beat per high cycle.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `done_id`, out, `$clog2(NUM_REQ)`: index of the owner; valid while `done`=1.
- `err_timeout`, out, 1: qualifies `done`; high means the transfer timed out.
- `err_extra`, out, 1: one-cycle pulse when `rx_ack`=1 is seen in the DONE cycle.

## Operation
- All outputs are registered. In reset every output is 0, the state is IDLE, the RR pointer is 0 and all counters are 0.
- IDLE
  - If `req` is nonzero, pick the first set bit searching upward from the RR pointer, with wrap.
  - Load `grant` with that requester and go to TX.
- TX (1 cycle): `tx_pulse`=1. `rx_ack` is ignored. Go to WAIT.
- WAIT
  - Every cycle with `rx_ack`=1 increments `ack_cnt`. The counter width is `$clog2(ACK_COUNT+1)`.
  - Every cycle increments `to_cnt`.
  - Exit to DONE with `err_timeout`=0 when `ack_cnt` reaches `ACK_COUNT`.
  - Exit to DONE with `err_timeout`=1 when `to_cnt` reaches `TIMEOUT` first.
  - If the final ack and the timeout land on the same edge, success wins (`err_timeout`=0).
- DONE (1 cycle)
  - `done`=1 and `done_id` = winner index.
  - RR pointer := (winner+1) mod `NUM_REQ`.
  - `ack_cnt` and `to_cnt` are cleared.
  - `rx_ack`=1 in this cycle pulses `err_extra` on the next cycle and is otherwise discarded.
  - Go to IDLE. `grant` drops on entry to IDLE.
- The deassertion of `req` by the owner mid-transfer is ignored; the transfer runs to DONE.
- `rx_ack` in IDLE is ignored and not counted.
- Asynchronous reset mid-transfer aborts immediately. No `done` is produced, and the pointer returns to 0.

## Timing
- `req` seen at edge N: `grant` and `tx_pulse` high in cycle N+1. WAIT starts in cycle N+2.
- Minimum transfer, with `ACK_COUNT` acks back-to-back from N+2: `done` is high in cycle N+2+`ACK_COUNT`. `grant` is low and IDLE sampling happens at N+3+`ACK_COUNT`.
- Next `tx_pulse` for a pending requester comes no earlier than N+4+`ACK_COUNT`. The minimum `tx_pulse` spacing is therefore `ACK_COUNT`+3 cycles.
- Timeout case: `done` with `err_timeout`=1 occurs in cycle N+2+`TIMEOUT`.
- `tx_pulse` is never high two consecutive cycles and is never high while `busy` was already high the previous cycle.

## Test plan
- Single transfer, defaults: `req`=4'b0001 held; acks in WAIT cycles 1 and 3 with a gap in cycle 2 → `tx_pulse` 1 cycle after the request. `done`=1 one cycle after the 2nd ack, with `done_id`=0 and `err_timeout`=0.
- Round-robin fairness: `req`=4'b1011 held continuously, 2 back-to-back acks per transfer → grants in the order 0, 1, 3, 0. Each `done_id` matches and there is no starvation.
- Timeout: `req`=4'b0100, only 1 ack sent → `done`=1 and `err_timeout`=1 exactly 16 cycles after WAIT entry, with `done_id`=2. The pointer then advances to 3.
- Boundary ack/timeout: `TIMEOUT`=2, `ACK_COUNT`=2, acks in both WAIT cycles → `err_timeout`=0. Separately, a third `rx_ack` in the DONE cycle → `err_extra` pulses once.
- Ignored acks: `rx_ack`=1 during IDLE and the TX cycle, then 2 WAIT acks → completion after exactly the 2 WAIT acks (ack count 2, not 4).
- Reset mid-WAIT: assert `rst_n`=0 asynchronously after 1 ack → all outputs are 0 immediately. After release, `req`=4'b0010 is granted to requester 1 with a fresh ack count.

Source files
------------

// File: rtl/tx_ack_scheduler.sv
// tx_ack_scheduler
//   Round-robin arbiter that shares one transmitter between NUM_REQ requesters.
//   Each granted transfer emits a single tx_pulse, then counts ACK_COUNT beats on
//   rx_ack (gaps allowed). The transfer ends in a one-cycle done, flagged by
//   err_timeout if TIMEOUT WAIT cycles pass first.
//
// Ports
//   clk, rst_n      : clock (rising edge); asynchronous active-low reset
//   req[NUM_REQ]    : level requests, sampled only while idle
//   grant[NUM_REQ]  : one-hot owner, held from TX through DONE
//   tx_pulse        : one-cycle transmit strobe
//   rx_ack          : acknowledge beat, one per high cycle
//   busy            : high whenever not idle
//   done, done_id   : one-cycle completion pulse and the owner's index
//   err_timeout     : qualifies done; the transfer timed out
//   err_extra       : pulse one cycle after an ack arrives in the DONE cycle
module tx_ack_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ACK_COUNT = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       tx_pulse,
    input  logic                       rx_ack,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       err_timeout,
    output logic                       err_extra
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(ACK_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, TX, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      ack_q, ack_d;
    logic [TW-1:0]      to_q, to_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IW-1:0]      done_id_q, done_id_d;
    logic               err_to_q, err_to_d;
    logic               err_ex_q, err_ex_d;

    // Round-robin search: first set request at or above ptr_q, wrapping.
    // cand is one bit wider so ptr+i can exceed NUM_REQ before the wrap.
    logic [IW:0]   cand;
    logic          found;
    logic [IW-1:0] pick;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    logic ack_hit, to_hit;
    assign ack_hit = rx_ack && (ack_q == AW'(ACK_COUNT - 1));
    assign to_hit  = (to_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        to_d      = to_q;
        tx_d      = 1'b0;
        done_d    = 1'b0;
        done_id_d = '0;
        err_to_d  = 1'b0;
        err_ex_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = TX;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                    owner_d        = pick;
                    tx_d           = 1'b1;
                end
            end
            TX: state_d = WAIT;
            WAIT: begin
                ack_d = ack_q + AW'(rx_ack);
                to_d  = to_q + TW'(1);
                // Final ack is tested first so it wins a tie with the timeout.
                if (ack_hit || to_hit) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    err_to_d  = !ack_hit;
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                ptr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                ack_d    = '0;
                to_d     = '0;
                err_ex_d = rx_ack;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            to_q      <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_to_q  <= 1'b0;
            err_ex_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            to_q      <= to_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_to_q  <= err_to_d;
            err_ex_q  <= err_ex_d;
        end
    end

    assign grant       = grant_q;
    assign tx_pulse    = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign err_timeout = err_to_q;
    assign err_extra   = err_ex_q;

endmodule

// File: tb/tb_tx_ack_scheduler.sv
// Bench for tx_ack_scheduler: u0 uses default parameters, u1 uses TIMEOUT=2 for
// the ack/timeout tie. Expected behaviour comes from a transfer-level model:
// the winner is found by a modular scan of req from the model pointer, and the
// DONE cycle is the WAIT index of the ACK_COUNT-th ack or TIMEOUT, whichever is
// first. Inputs are driven and outputs sampled on the falling edge.
module tb_tx_ack_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req0, req1;
    logic       ack0, ack1;
    logic [3:0] g0, g1;
    logic       tx0, tx1, busy0, busy1, done0, done1, eto0, eto1, eex0, eex1;
    logic [1:0] id0, id1;

    tx_ack_scheduler u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .grant(g0), .tx_pulse(tx0),
        .rx_ack(ack0), .busy(busy0), .done(done0), .done_id(id0),
        .err_timeout(eto0), .err_extra(eex0));

    tx_ack_scheduler #(.NUM_REQ(4), .ACK_COUNT(2), .TIMEOUT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1), .tx_pulse(tx1),
        .rx_ack(ack1), .busy(busy1), .done(done1), .done_id(id1),
        .err_timeout(eto1), .err_extra(eex1));

    int checks = 0;
    int failures = 0;
    int sel = 0;
    int ptr[2];
    bit prev_extra[2];

    // {grant, tx_pulse, busy, done, done_id, err_timeout, err_extra}
    function automatic logic [10:0] obs();
        if (sel != 0) return {g1, tx1, busy1, done1, id1, eto1, eex1};
        return {g0, tx0, busy0, done0, id0, eto0, eex0};
    endfunction

    task automatic drive(input logic [3:0] r, input logic a);
        if (sel != 0) begin req1 = r; ack1 = a; req0 = '0; ack0 = 1'b0; end
        else          begin req0 = r; ack0 = a; req1 = '0; ack1 = 1'b0; end
    endtask

    // One full transfer starting in an IDLE cycle; ends after the DONE cycle.
    task automatic run_xfer(input logic [3:0] r, input logic [31:0] pat,
                            input logic txack, input logic extra,
                            input string name, output logic [1:0] id_o);
        int ac, to, cnt, m, win;
        logic [3:0]  oh;
        logic [10:0] exp;
        ac = 2; to = (sel != 0) ? 2 : 16; cnt = 0; m = to; win = 0;
        for (int w = 0; w < to; w++) begin
            if (pat[w]) cnt++;
            if (cnt == ac) begin m = w + 1; break; end
        end
        for (int i = 3; i >= 0; i--)
            if (((r >> ((ptr[sel] + i) % 4)) & 4'd1) != 4'd0) win = (ptr[sel] + i) % 4;
        oh = 4'b0001 << win;

        @(negedge clk);
        exp = {4'b0, 1'b0, 1'b0, 1'b0, 2'b0, 1'b0, prev_extra[sel]};
        checks++;
        if (obs() !== exp) begin
            failures++; $display("FAIL %s idle got=%b exp=%b", name, obs(), exp);
        end
        drive(r, 1'($urandom % 2));

        @(negedge clk);
        exp = {oh, 1'b1, 1'b1, 1'b0, 2'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp) begin
            failures++; $display("FAIL %s tx got=%b exp=%b", name, obs(), exp);
        end
        drive(r, txack);

        for (int k = 0; k < m; k++) begin
            @(negedge clk);
            exp = {oh, 1'b0, 1'b1, 1'b0, 2'b0, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp) begin
                failures++; $display("FAIL %s wait%0d got=%b exp=%b", name, k, obs(), exp);
            end
            drive(r, pat[k]);
        end

        @(negedge clk);
        exp = {oh, 1'b0, 1'b1, 1'b1, 2'(win), (cnt < ac), 1'b0};
        checks++;
        if (obs() !== exp) begin
            failures++; $display("FAIL %s done got=%b exp=%b", name, obs(), exp);
        end
        id_o = (sel != 0) ? id1 : id0;
        drive(r, extra);
        prev_extra[sel] = extra;
        ptr[sel] = (win + 1) % 4;
    endtask

    // Idle cycles with req=0; a=2 means random rx_ack.
    task automatic test_idle(input int n, input int a);
        logic [10:0] exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp = {10'b0, prev_extra[sel]};
            checks++;
            if (obs() !== exp) begin
                failures++; $display("FAIL idle%0d got=%b exp=%b", k, obs(), exp);
            end
            prev_extra[sel] = 1'b0;
            drive(4'b0, (a == 2) ? 1'($urandom % 2) : 1'(a));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = '0; req1 = '0; ack0 = 1'b0; ack1 = 1'b0;
        #12;
        checks++;
        if ({g0, tx0, busy0, done0, id0, eto0, eex0, g1, tx1, busy1, done1, id1, eto1, eex1} !== 22'b0) begin
            failures++; $display("FAIL reset got nonzero outputs");
        end
        @(negedge clk);
        rst_n = 1'b1;
        ptr[0] = 0; ptr[1] = 0; prev_extra[0] = 1'b0; prev_extra[1] = 1'b0;
    endtask

    task automatic test_fairness();
        logic [1:0] id;
        int order[4] = '{0, 1, 3, 0};
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            run_xfer(4'b1011, 32'b11, 1'b0, 1'b0, "fair", id);
            checks++;
            if (id !== 2'(order[i])) begin
                failures++; $display("FAIL fair_order%0d got=%0d exp=%0d", i, id, order[i]);
            end
        end
        test_idle(2, 0);
    endtask

    task automatic test_single();
        logic [1:0] id;
        sel = 0;
        run_xfer(4'b0001, 32'b101, 1'b0, 1'b0, "single", id);
        test_idle(2, 0);
    endtask

    task automatic test_timeout();
        logic [1:0] id;
        sel = 0;
        run_xfer(4'b0100, 32'b1, 1'b0, 1'b0, "timeout", id);
        test_idle(1, 0);
        // pointer should now sit at 3
        run_xfer(4'b1111, 32'b11, 1'b0, 1'b0, "after_to", id);
        checks++;
        if (id !== 2'd3) begin
            failures++; $display("FAIL ptr_after_timeout got=%0d exp=3", id);
        end
        test_idle(1, 0);
    endtask

    task automatic test_ignored_acks();
        logic [1:0] id;
        sel = 0;
        test_idle(3, 1);
        run_xfer(4'b0010, 32'b11, 1'b1, 1'b0, "ignored", id);
        test_idle(1, 0);
    endtask

    task automatic test_boundary();
        logic [1:0] id;
        sel = 1;
        run_xfer(4'b0001, 32'b11, 1'b0, 1'b1, "tie", id);
        test_idle(2, 0);
        run_xfer(4'b0001, 32'b10, 1'b0, 1'b0, "short_to", id);
        test_idle(1, 0);
        sel = 0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] id;
        sel = 0;
        @(negedge clk); drive(4'b0100, 1'b0);
        @(negedge clk); drive(4'b0100, 1'b0);
        @(negedge clk); drive(4'b0100, 1'b1);
        @(negedge clk); drive(4'b0100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({g0, tx0, busy0, done0, id0, eto0, eex0} !== 11'b0) begin
            failures++; $display("FAIL reset_mid got=%b exp=0", {g0, tx0, busy0, done0, id0, eto0, eex0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0, 1'b0);
        ptr[0] = 0; ptr[1] = 0; prev_extra[0] = 1'b0; prev_extra[1] = 1'b0;
        run_xfer(4'b1001, 32'b11, 1'b0, 1'b0, "ptr_reset", id);
        checks++;
        if (id !== 2'd0) begin
            failures++; $display("FAIL ptr_reset got=%0d exp=0", id);
        end
        test_idle(1, 0);
        run_xfer(4'b0010, 32'b101, 1'b0, 1'b0, "fresh_cnt", id);
        test_idle(1, 0);
    endtask

    task automatic test_random();
        logic [1:0] id;
        logic [3:0] r;
        sel = 0;
        for (int i = 0; i < 30; i++) begin
            r = 4'($urandom_range(1, 15));
            run_xfer(r, $urandom & $urandom, 1'($urandom % 2), 1'($urandom % 2), "rand", id);
            if ($urandom % 3 == 0) test_idle(1 + int'($urandom % 2), 2);
        end
        test_idle(2, 2);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_timeout();
        test_ignored_acks();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
